// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: control-word layout,
// access sizes, exception causes and FSM states.
package mem_pkg;

  localparam int CW_WIDTH    = 35;
  localparam int MEM_RD_BIT  = 10;
  localparam int MEM_WR_BIT  = 11;
  localparam int MEM_SIZE_LO = 12;
  localparam int MEM_SIZE_HI = 13;
  localparam int MEM_UNS_BIT = 14;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'd0,
    SIZE_HALF     = 2'd1,
    SIZE_WORD     = 2'd2,
    SIZE_WORD_ALT = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    EXC_LOAD_MISALIGN  = 2'd0,
    EXC_STORE_MISALIGN = 2'd1,
    EXC_BUS            = 2'd2,
    EXC_ILLEGAL        = 2'd3
  } exc_cause_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every byte lane carries it.
  function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory request/grant/response bus between the MEM stage and memory.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed lane of a load response and sign/zero extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[7:0];
    case (offset)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: data = {{24{~uns & lane_b[7]}}, lane_b};
      SIZE_HALF: data = {{16{~uns & lane_h[15]}}, lane_h};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on the data bus, checks alignment,
// enforces a response timeout and presents one registered result per instruction.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CW_WIDTH-1:0] control_word_in,
  input  logic [31:0]         addr_in,
  input  logic [31:0]         store_data_in,
  input  logic [31:0]         PC_in,
  output logic                stall_out,
  dmem_if.master              dmem,
  output logic                out_valid,
  output logic [CW_WIDTH-1:0] control_word_out,
  output logic [31:0]         PC_out,
  output logic [31:0]         result_out,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic [31:0]         exc_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic                orphan;
  logic [CW_WIDTH-1:0] ctrl_q;
  logic [31:0]         addr_q, pc_q;
  logic                req_we;
  logic [31:0]         req_addr, req_wdata;
  logic [3:0]          req_be;

  logic       in_rd, in_wr, in_misalign, capture, timeout_hit;
  mem_size_e  in_size;
  logic [31:0] load_data;

  logic        complete, comp_exc, set_orphan;
  exc_cause_e  comp_cause;
  logic [31:0] comp_result;

  assign in_rd       = control_word_in[MEM_RD_BIT];
  assign in_wr       = control_word_in[MEM_WR_BIT];
  assign in_size     = mem_size_e'(control_word_in[MEM_SIZE_HI:MEM_SIZE_LO]);
  assign in_misalign = ((in_size == SIZE_HALF) && addr_in[0]) ||
                       (in_size[1] && (addr_in[1:0] != 2'b00));
  // A pending orphaned response blocks new captures until it drains.
  assign capture     = (state == IDLE) && !orphan && in_valid;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  assign stall_out  = (state != IDLE) || orphan;
  assign dmem.req   = (state == REQ);
  assign dmem.we    = req_we;
  assign dmem.addr  = req_addr;
  assign dmem.be    = req_be;
  assign dmem.wdata = req_wdata;

  mem_load_align u_align (
    .rdata  (dmem.rdata),
    .offset (addr_q[1:0]),
    .size   (mem_size_e'(ctrl_q[MEM_SIZE_HI:MEM_SIZE_LO])),
    .uns    (ctrl_q[MEM_UNS_BIT]),
    .data   (load_data)
  );

  always_comb begin
    next_state  = state;
    complete    = 1'b0;
    comp_exc    = 1'b0;
    comp_cause  = EXC_BUS;
    comp_result = 32'b0;
    set_orphan  = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          if (in_rd && in_wr) begin
            complete   = 1'b1;
            comp_exc   = 1'b1;
            comp_cause = EXC_ILLEGAL;
          end else if ((in_rd || in_wr) && in_misalign) begin
            complete   = 1'b1;
            comp_exc   = 1'b1;
            comp_cause = in_wr ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
          end else if (in_rd || in_wr) begin
            next_state = REQ;
          end else begin
            complete    = 1'b1;
            comp_result = addr_in;
          end
        end
      end
      REQ: begin
        if (dmem.gnt) next_state = WAIT;
        // A grant in the expiring cycle still owes a response, which must be drained.
        if (timeout_hit) begin
          next_state = IDLE;
          complete   = 1'b1;
          comp_exc   = 1'b1;
          set_orphan = dmem.gnt;
        end
      end
      WAIT: begin
        if (dmem.rvalid) begin
          next_state = IDLE;
          complete   = 1'b1;
          if (dmem.err) comp_exc = 1'b1;
          else comp_result = ctrl_q[MEM_RD_BIT] ? load_data : addr_q;
        end else if (timeout_hit) begin
          next_state = IDLE;
          complete   = 1'b1;
          comp_exc   = 1'b1;
          set_orphan = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      orphan <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + CNT_W'(1);
      if (set_orphan) orphan <= 1'b1;
      else if (orphan && dmem.rvalid) orphan <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q           <= '0;
      addr_q           <= '0;
      pc_q             <= '0;
      req_we           <= 1'b0;
      req_addr         <= '0;
      req_be           <= '0;
      req_wdata        <= '0;
      out_valid        <= 1'b0;
      control_word_out <= '0;
      PC_out           <= '0;
      result_out       <= '0;
      exc_valid        <= 1'b0;
      exc_cause        <= '0;
      exc_addr         <= '0;
    end else begin
      out_valid <= complete;
      if (capture) begin
        ctrl_q    <= control_word_in;
        addr_q    <= addr_in;
        pc_q      <= PC_in;
        req_we    <= in_wr;
        req_addr  <= {addr_in[31:2], 2'b00};
        req_be    <= byte_enable(in_size, addr_in[1:0]);
        req_wdata <= store_lanes(in_size, store_data_in);
      end
      if (complete) begin
        control_word_out <= (state == IDLE) ? control_word_in : ctrl_q;
        PC_out           <= (state == IDLE) ? PC_in : pc_q;
        result_out       <= comp_result;
        exc_valid        <= comp_exc;
        exc_cause        <= comp_cause;
        exc_addr         <= comp_exc ? ((state == IDLE) ? addr_in : addr_q) : 32'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a hand-driven data-memory slave.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [34:0] control_word_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data_in = '0;
  logic [31:0] PC_in = '0;
  logic        stall_out;
  logic        out_valid;
  logic [34:0] control_word_out;
  logic [31:0] PC_out;
  logic [31:0] result_out;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int num_checks = 0;
  int num_fails  = 0;
  int req_cycles;
  logic [34:0] cw;

  dmem_if bus ();

  mem_stage #(.TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .control_word_in  (control_word_in),
    .addr_in          (addr_in),
    .store_data_in    (store_data_in),
    .PC_in            (PC_in),
    .stall_out        (stall_out),
    .dmem             (bus),
    .out_valid        (out_valid),
    .control_word_out (control_word_out),
    .PC_out           (PC_out),
    .result_out       (result_out),
    .exc_valid        (exc_valid),
    .exc_cause        (exc_cause),
    .exc_addr         (exc_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] mkCw(input logic rd, input logic wr, input logic [1:0] size,
                                       input logic uns);
    logic [34:0] c;
    c       = 35'h4_0000_0005;
    c[10]   = rd;
    c[11]   = wr;
    c[13:12] = size;
    c[14]   = uns;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [34:0] c, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] pc);
    in_valid        = valid;
    control_word_in = c;
    addr_in         = a;
    store_data_in   = sd;
    PC_in           = pc;
  endtask

  task automatic checkOutput(input string tag, input logic [34:0] observed, input logic [34:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.err    = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_stall", stall_out, 0);
    checkOutput("rst_req", bus.req, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result_out, 0);
    checkOutput("rst_exc", exc_valid, 0);
    rst = 1'b1;
    tick();

    // Load byte signed at 0x1003
    $display("[TB] load byte signed");
    cw = mkCw(1, 0, 2'd0, 0);
    applyStimulus(1, cw, 32'h0000_1003, 32'h0, 32'h0000_0100);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    checkOutput("lb_req", bus.req, 1);
    checkOutput("lb_be", bus.be, 4'b1000);
    checkOutput("lb_addr", bus.addr, 32'h0000_1000);
    checkOutput("lb_we", bus.we, 0);
    checkOutput("lb_stall1", stall_out, 1);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    checkOutput("lb_req_wait", bus.req, 0);
    checkOutput("lb_stall2", stall_out, 1);
    checkOutput("lb_ov_early", out_valid, 0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h8012_3456;
    tick();
    bus.rvalid = 1'b0;
    checkOutput("lb_out_valid", out_valid, 1);
    checkOutput("lb_result", result_out, 32'hFFFF_FF80);
    checkOutput("lb_exc", exc_valid, 0);
    checkOutput("lb_stall3", stall_out, 0);
    checkOutput("lb_pc", PC_out, 32'h0000_0100);
    checkOutput("lb_cw", control_word_out, cw);
    tick();
    checkOutput("lb_ov_pulse", out_valid, 0);
    checkOutput("lb_result_hold", result_out, 32'hFFFF_FF80);

    // Store half at 0x2002 with a grant delayed by four cycles
    $display("[TB] store half");
    applyStimulus(1, mkCw(0, 1, 2'd1, 0), 32'h0000_2002, 32'h0000_ABCD, 32'h0000_0200);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req === 1'b1) req_cycles++;
      tick();
    end
    if (bus.req === 1'b1) req_cycles++;
    checkOutput("sh_be", bus.be, 4'b1100);
    checkOutput("sh_wdata", bus.wdata, 32'hABCD_ABCD);
    checkOutput("sh_we", bus.we, 1);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    checkOutput("sh_req_cycles", req_cycles, 5);
    checkOutput("sh_req_dropped", bus.req, 0);
    bus.rvalid = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    checkOutput("sh_out_valid", out_valid, 1);
    checkOutput("sh_exc", exc_valid, 0);

    // Misaligned word load
    $display("[TB] misaligned word load");
    applyStimulus(1, mkCw(1, 0, 2'd2, 0), 32'h0000_3001, 32'h0, 32'h0000_0300);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    checkOutput("mis_req", bus.req, 0);
    checkOutput("mis_out_valid", out_valid, 1);
    checkOutput("mis_exc", exc_valid, 1);
    checkOutput("mis_cause", exc_cause, 0);
    checkOutput("mis_addr", exc_addr, 32'h0000_3001);
    checkOutput("mis_result", result_out, 0);

    // Timeout in WAIT, orphaned response, then a blocked follow-on load
    $display("[TB] timeout");
    applyStimulus(1, mkCw(1, 0, 2'd2, 0), 32'h0000_4000, 32'h0, 32'h0000_0400);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("to_not_yet", out_valid, 0);
    tick();
    checkOutput("to_out_valid", out_valid, 1);
    checkOutput("to_exc", exc_valid, 1);
    checkOutput("to_cause", exc_cause, 2);
    checkOutput("to_addr", exc_addr, 32'h0000_4000);
    checkOutput("to_orphan_stall", stall_out, 1);
    applyStimulus(1, mkCw(1, 0, 2'd2, 0), 32'h0000_5004, 32'h0, 32'h0000_0500);
    tick();
    checkOutput("orph_no_req", bus.req, 0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0;
    checkOutput("orph_discard", out_valid, 0);
    checkOutput("orph_no_req2", bus.req, 0);
    checkOutput("orph_cleared", stall_out, 0);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    checkOutput("next_req", bus.req, 1);
    checkOutput("next_addr", bus.addr, 32'h0000_5004);
    bus.gnt = 1'b1;
    tick();
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1234_5678;
    tick();
    bus.rvalid = 1'b0;
    checkOutput("next_result", result_out, 32'h1234_5678);
    checkOutput("next_pc", PC_out, 32'h0000_0500);

    // Response error on an unsigned half load
    $display("[TB] response error");
    applyStimulus(1, mkCw(1, 0, 2'd1, 1), 32'h0000_6002, 32'h0, 32'h0000_0600);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b1;
    bus.err    = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    bus.err    = 1'b0;
    checkOutput("err_exc", exc_valid, 1);
    checkOutput("err_cause", exc_cause, 2);
    checkOutput("err_result", result_out, 0);

    // Unsigned half load from the upper lane
    applyStimulus(1, mkCw(1, 0, 2'd1, 1), 32'h0000_6002, 32'h0, 32'h0000_0604);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    checkOutput("lhu_be", bus.be, 4'b1100);
    bus.gnt = 1'b1;
    tick();
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hBEEF_1234;
    tick();
    bus.rvalid = 1'b0;
    checkOutput("lhu_result", result_out, 32'h0000_BEEF);

    // Both read and write set
    $display("[TB] illegal access");
    applyStimulus(1, mkCw(1, 1, 2'd2, 0), 32'h0000_7000, 32'h0, 32'h0000_0700);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    checkOutput("ill_req", bus.req, 0);
    checkOutput("ill_exc", exc_valid, 1);
    checkOutput("ill_cause", exc_cause, 3);

    // Reset asserted while waiting for a response
    $display("[TB] reset in WAIT");
    applyStimulus(1, mkCw(1, 0, 2'd2, 0), 32'h0000_8000, 32'h0, 32'h0000_0800);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rw_stall", stall_out, 0);
    checkOutput("rw_req", bus.req, 0);
    checkOutput("rw_result", result_out, 0);
    checkOutput("rw_exc", exc_valid, 0);
    checkOutput("rw_pc", PC_out, 0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rw_no_ov", out_valid, 0);
    applyStimulus(1, mkCw(0, 0, 2'd0, 0), 32'hCAFE_0001, 32'h0, 32'h0000_0900);
    tick();
    applyStimulus(0, '0, 32'h0, 32'h0, 32'h0);
    checkOutput("nm_out_valid", out_valid, 1);
    checkOutput("nm_result", result_out, 32'hCAFE_0001);
    checkOutput("nm_exc", exc_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
